// File: rtl/prom_ldr_if.sv
// Fetch / byte-load bus for prom_ldr. The master side drives the requests;
// the slave side (prom_ldr) returns the registered fetch data and load status.
interface prom_ldr_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 15
);
    logic              FETCH_EN_ip;
    logic [ADDR_W-1:0] ADDR_ip;
    logic [DATA_W-1:0] DATA_op;
    logic              VALID_op;
    logic              LD_START_ip;
    logic [7:0]        LD_BYTE_ip;
    logic              LD_BYTE_VALID_ip;
    logic              LD_DONE_ip;
    logic              BUSY_op;
    logic [ADDR_W-1:0] LD_ADDR_op;
    logic              LD_ERR_op;

    modport master (
        output FETCH_EN_ip, ADDR_ip, LD_START_ip, LD_BYTE_ip, LD_BYTE_VALID_ip, LD_DONE_ip,
        input  DATA_op, VALID_op, BUSY_op, LD_ADDR_op, LD_ERR_op
    );

    modport slave (
        input  FETCH_EN_ip, ADDR_ip, LD_START_ip, LD_BYTE_ip, LD_BYTE_VALID_ip, LD_DONE_ip,
        output DATA_op, VALID_op, BUSY_op, LD_ADDR_op, LD_ERR_op
    );
endinterface

// File: rtl/prom_ldr.sv
// Program ROM with a byte-serial loader. In LOAD, bytes are assembled
// little-endian into words and written sequentially from address 0; in IDLE
// the memory serves single-cycle registered fetches.
module prom_ldr #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 15,
    parameter int DEPTH  = 8192
) (
    input  logic        CLK_ip,
    input  logic        RST_N_ip,
    prom_ldr_if.slave   bus
);
    localparam int NB    = (DATA_W + 7) / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = 3;
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  NB_M1_C = CNT_W'(NB - 1);

    typedef enum logic {ST_IDLE, ST_LOAD} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              busy_q;
    logic [ADDR_W-1:0] ld_addr_q;
    logic              ld_err_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              full_q;
    logic [DATA_W-1:0] asm_q;
    logic [DATA_W-1:0] asm_d;
    logic [8*NB-1:0]   wide_d;
    logic              byte_acc;
    logic              word_wr;

    // Zero-initialised storage; not touched by reset.
    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

    // Merge the incoming byte into the assembly word and decode write strobes.
    always_comb begin
        wide_d = (8*NB)'(asm_q);
        for (int k = 0; k < NB; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                wide_d[k*8 +: 8] = bus.LD_BYTE_ip;
            end
        end
        asm_d    = wide_d[DATA_W-1:0];
        byte_acc = (state_q == ST_LOAD) && !bus.LD_START_ip && bus.LD_BYTE_VALID_ip && !full_q;
        word_wr  = byte_acc && (cnt_q == NB_M1_C);
    end

    // Bits of the last byte beyond DATA_W are intentionally dropped.
    wire unused_wide = ^wide_d;

    // Assembly register holds the partial word; stale bytes are always overwritten.
    always_ff @(posedge CLK_ip) begin
        if (byte_acc) begin
            asm_q <= asm_d;
        end
    end

    // Single write port, fed by the loader.
    always_ff @(posedge CLK_ip) begin
        if (word_wr) begin
            mem_q[ld_addr_q[IDX_W-1:0]] <= asm_d;
        end
    end

    // Control FSM with registered fetch and load-status outputs.
    always_ff @(posedge CLK_ip or negedge RST_N_ip) begin
        if (!RST_N_ip) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            ld_addr_q <= '0;
            ld_err_q  <= 1'b0;
            cnt_q     <= '0;
            full_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.LD_START_ip) begin
                // Start or restart: a pending partial word is abandoned.
                state_q   <= ST_LOAD;
                busy_q    <= 1'b1;
                ld_addr_q <= '0;
                ld_err_q  <= 1'b0;
                cnt_q     <= '0;
                full_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.FETCH_EN_ip) begin
                            valid_q <= 1'b1;
                            if ({1'b0, bus.ADDR_ip} < DEPTH_C) begin
                                data_q <= mem_q[bus.ADDR_ip[IDX_W-1:0]];
                            end else begin
                                data_q <= '0;
                            end
                        end
                    end
                    ST_LOAD: begin
                        if (bus.LD_BYTE_VALID_ip && full_q) begin
                            ld_err_q <= 1'b1;
                        end else if (word_wr) begin
                            cnt_q <= '0;
                            if (ld_addr_q == LAST_C) begin
                                full_q <= 1'b1;
                            end else begin
                                ld_addr_q <= ld_addr_q + 1'b1;
                            end
                        end else if (byte_acc) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        // The same-cycle byte has been handled above; done only drops the partial word.
                        if (bus.LD_DONE_ip) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            cnt_q   <= '0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.DATA_op    = data_q;
    assign bus.VALID_op   = valid_q;
    assign bus.BUSY_op    = busy_q;
    assign bus.LD_ADDR_op = ld_addr_q;
    assign bus.LD_ERR_op  = ld_err_q;
endmodule

// File: tb/tb_prom_ldr.sv
// Directed bench for prom_ldr (DEPTH=4 so overflow is reachable quickly).
// Fetch results are checked by a scoreboard monitor; status outputs directly.
module tb_prom_ldr;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 15;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [DATA_W-1:0] exp_q [$];

    prom_ldr_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    prom_ldr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .CLK_ip   (clk),
        .RST_N_ip (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every valid fetch result must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.VALID_op === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid: got data 0x%0h, expected no fetch result", bus.DATA_op);
            end else begin
                chk("fetch_data", 32'(bus.DATA_op), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.FETCH_EN_ip      = 1'b0;
        bus.ADDR_ip          = '0;
        bus.LD_START_ip      = 1'b0;
        bus.LD_BYTE_ip       = '0;
        bus.LD_BYTE_VALID_ip = 1'b0;
        bus.LD_DONE_ip       = 1'b0;
    endtask

    task automatic ld_start();
        bus.LD_START_ip = 1'b1;
        tick();
        clr();
    endtask

    task automatic ld_byte(input logic [7:0] b, input logic done);
        bus.LD_BYTE_ip       = b;
        bus.LD_BYTE_VALID_ip = 1'b1;
        bus.LD_DONE_ip       = done;
        tick();
        clr();
    endtask

    task automatic ld_done();
        bus.LD_DONE_ip = 1'b1;
        tick();
        clr();
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        bus.FETCH_EN_ip = 1'b1;
        bus.ADDR_ip     = a;
        exp_q.push_back(exp);
        tick();
        clr();
    endtask

    initial begin
        clr();
        repeat (2) tick();
        #2 rst_n = 1'b1;
        tick();
        chk("reset_data",    32'(bus.DATA_op), 32'h0);
        chk("reset_valid",   32'(bus.VALID_op), 32'h0);
        chk("reset_busy",    32'(bus.BUSY_op), 32'h0);
        chk("reset_ld_addr", 32'(bus.LD_ADDR_op), 32'h0);
        chk("reset_ld_err",  32'(bus.LD_ERR_op), 32'h0);

        // Basic load of two words, then fetch both.
        ld_start();
        chk("busy_after_start", 32'(bus.BUSY_op), 32'h1);
        ld_byte(8'h34, 1'b0);
        ld_byte(8'h12, 1'b0);
        ld_byte(8'h00, 1'b0);
        ld_byte(8'h5C, 1'b0);
        ld_done();
        chk("busy_after_done", 32'(bus.BUSY_op), 32'h0);
        chk("ld_addr_two",     32'(bus.LD_ADDR_op), 32'h2);
        fetch(13'd0, 15'h1234);
        fetch(13'd1, 15'h5C00);
        tick();

        // Upper bits of the last byte are truncated.
        ld_start();
        ld_byte(8'hFF, 1'b0);
        ld_byte(8'hFF, 1'b0);
        ld_done();
        chk("ld_addr_one", 32'(bus.LD_ADDR_op), 32'h1);
        fetch(13'd0, 15'h7FFF);

        // Partial word is dropped on done.
        ld_start();
        ld_byte(8'hAA, 1'b0);
        ld_done();
        chk("partial_ld_addr", 32'(bus.LD_ADDR_op), 32'h0);
        chk("partial_busy",    32'(bus.BUSY_op), 32'h0);
        fetch(13'd0, 15'h7FFF);

        // Completing byte together with done is still written.
        ld_start();
        ld_byte(8'h01, 1'b0);
        ld_byte(8'h00, 1'b1);
        chk("byte_done_busy",    32'(bus.BUSY_op), 32'h0);
        chk("byte_done_ld_addr", 32'(bus.LD_ADDR_op), 32'h1);
        fetch(13'd0, 15'h0001);
        fetch(13'd1, 15'h5C00);

        // Out-of-range fetch returns zero.
        fetch(13'd4, 15'h0000);
        fetch(13'd5000, 15'h0000);

        // Overflow: five words into a four-word memory.
        ld_start();
        for (int k = 0; k < 4; k++) begin
            ld_byte(8'(8'h10 + k), 1'b0);
            ld_byte(8'(8'h20 + k), 1'b0);
        end
        chk("full_ld_addr", 32'(bus.LD_ADDR_op), 32'h3);
        chk("full_no_err",  32'(bus.LD_ERR_op), 32'h0);
        ld_byte(8'h14, 1'b0);
        chk("ovf_err",     32'(bus.LD_ERR_op), 32'h1);
        chk("ovf_ld_addr", 32'(bus.LD_ADDR_op), 32'h3);
        ld_byte(8'h24, 1'b0);
        ld_done();
        chk("err_held_idle",     32'(bus.LD_ERR_op), 32'h1);
        chk("ld_addr_held_idle", 32'(bus.LD_ADDR_op), 32'h3);
        fetch(13'd0, 15'h2010);
        fetch(13'd1, 15'h2111);
        fetch(13'd2, 15'h2212);
        fetch(13'd3, 15'h2313);
        ld_start();
        chk("restart_clears_err",  32'(bus.LD_ERR_op), 32'h0);
        chk("restart_clears_addr", 32'(bus.LD_ADDR_op), 32'h0);
        ld_done();

        // Fetch together with start loses; fetch during load is ignored.
        bus.FETCH_EN_ip = 1'b1;
        bus.ADDR_ip     = 13'd1;
        bus.LD_START_ip = 1'b1;
        tick();
        clr();
        chk("arb_start_valid", 32'(bus.VALID_op), 32'h0);
        chk("arb_start_busy",  32'(bus.BUSY_op), 32'h1);
        bus.FETCH_EN_ip = 1'b1;
        bus.ADDR_ip     = 13'd0;
        tick();
        clr();
        chk("arb_load_valid", 32'(bus.VALID_op), 32'h0);
        chk("arb_load_data",  32'(bus.DATA_op), 32'h2313);
        ld_done();

        // Asynchronous reset in the middle of a load.
        ld_start();
        ld_byte(8'hCD, 1'b0);
        ld_byte(8'h0B, 1'b0);
        ld_byte(8'h77, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_data",    32'(bus.DATA_op), 32'h0);
        chk("areset_valid",   32'(bus.VALID_op), 32'h0);
        chk("areset_busy",    32'(bus.BUSY_op), 32'h0);
        chk("areset_ld_addr", 32'(bus.LD_ADDR_op), 32'h0);
        chk("areset_ld_err",  32'(bus.LD_ERR_op), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        fetch(13'd0, 15'h0BCD);
        fetch(13'd1, 15'h2111);

        repeat (3) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end
endmodule
